// File: rtl/adder_pkg.sv
// Shared constants and a reference sum helper for the ripple adder family.
package adder_pkg;

    localparam int MAX_WIDTH = 64;

    localparam logic [MAX_WIDTH-1:0] SUM_RST   = '0;
    localparam logic                 CARRY_RST = 1'b0;

    // Returns {carry, sum} of a + b + cin truncated to width+1 bits.
    function automatic logic [MAX_WIDTH:0] ref_add(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic                 cin,
        input int                   width
    );
        logic [MAX_WIDTH:0] full;
        logic [MAX_WIDTH:0] mask;
        full = {1'b0, a} + {1'b0, b} + {{MAX_WIDTH{1'b0}}, cin};
        mask = ({{MAX_WIDTH{1'b0}}, 1'b1} << (width + 1)) - 1'b1;
        return full & mask;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder used as the leaf of the ripple chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_half;

    assign w_half = a ^ b;
    assign s      = w_half ^ ci;
    assign co     = (a & b) | (ci & w_half);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH cells with a reset-cleared registered copy of the result.
module full_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;

    assign w_carry[0] = carry_in;

    // Carry ripples from bit 0 upward through one cell per bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder_cell u_cell (
                .a  (a[gi]),
                .b  (b[gi]),
                .ci (w_carry[gi]),
                .s  (w_sum[gi]),
                .co (w_carry[gi+1])
            );
        end
    endgenerate

    assign sum       = w_sum;
    assign carry_out = w_carry[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= SUM_RST[WIDTH-1:0];
            r_carry <= CARRY_RST;
        end else begin
            r_sum   <= w_sum;
            r_carry <= w_carry[WIDTH];
        end
    end

    assign sum_q       = r_sum;
    assign carry_out_q = r_carry;

endmodule

// File: tb/tb_full_adder.sv
// Directed and randomized checks of full_adder at WIDTH=1 and WIDTH=8.
module tb_full_adder;
    import adder_pkg::*;

    logic       clk;
    logic       rst_n;

    logic       a1, b1, c1;
    logic       sum1, co1, sumQ1, coQ1;

    logic [7:0] a8, b8;
    logic       c8;
    logic [7:0] sum8, sumQ8;
    logic       co8, coQ8;

    int errors;
    int checks;

    full_adder #(.WIDTH(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a1),
        .b           (b1),
        .carry_in    (c1),
        .sum         (sum1),
        .carry_out   (co1),
        .sum_q       (sumQ1),
        .carry_out_q (coQ1)
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a8),
        .b           (b8),
        .carry_in    (c8),
        .sum         (sum8),
        .carry_out   (co8),
        .sum_q       (sumQ8),
        .carry_out_q (coQ8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus1(input logic a, input logic b, input logic c);
        a1 = a;
        b1 = b;
        c1 = c;
    endtask

    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8 = a;
        b8 = b;
        c8 = c;
    endtask

    initial begin
        logic [7:0]  expSumTab;
        logic [7:0]  expCarryTab;
        logic [64:0] ref8;
        logic [64:0] ref1;
        logic [2:0]  vec;

        errors = 0;
        checks = 0;
        expSumTab   = 8'b1001_0110;
        expCarryTab = 8'b1110_1000;

        rst_n = 1'b0;
        applyStimulus1(1'b0, 1'b0, 1'b0);
        applyStimulus8(8'h00, 8'h00, 1'b0);
        #1;
        checkOutput("reset_sum_q1", {64'd0, sumQ1}, 65'd0);
        checkOutput("reset_co_q1", {64'd0, coQ1}, 65'd0);
        checkOutput("reset_q8", {56'd0, coQ8, sumQ8}, 65'd0);
        checkOutput("zero_comb8", {56'd0, co8, sum8}, 65'd0);

        // Exhaustive single-bit sweep, one vector every 4 time units.
        for (int i = 0; i < 8; i++) begin
            vec = i[2:0];
            applyStimulus1(vec[2], vec[1], vec[0]);
            #1;
            ref1 = ref_add({63'd0, vec[2]}, {63'd0, vec[1]}, vec[0], 1);
            checkOutput($sformatf("exh_tab_%0d", i), {63'd0, co1, sum1},
                        {63'd0, expCarryTab[i], expSumTab[i]});
            checkOutput($sformatf("exh_ref_%0d", i), {63'd0, co1, sum1}, ref1);
            #3;
        end

        // Combinational outputs stay live while reset holds the register at zero.
        @(negedge clk);
        applyStimulus1(1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("reset_hold_q1", {63'd0, coQ1, sumQ1}, 65'd0);
        checkOutput("reset_comb1", {63'd0, co1, sum1}, 65'b11);

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus1(1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("pre_first_edge_q1", {63'd0, coQ1, sumQ1}, 65'd0);
        @(posedge clk);
        #1;
        checkOutput("first_capture_q1", {63'd0, coQ1, sumQ1}, 65'b01);

        @(negedge clk);
        applyStimulus1(1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("hold_before_edge_q1", {63'd0, coQ1, sumQ1}, 65'b01);
        @(posedge clk);
        #1;
        checkOutput("reg_110_q1", {63'd0, coQ1, sumQ1}, 65'b10);

        // Mid-cycle reset clears the register without touching the sum path.
        @(negedge clk);
        applyStimulus1(1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("reg_111_q1", {63'd0, coQ1, sumQ1}, 65'b11);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_clear_q1", {63'd0, coQ1, sumQ1}, 65'd0);
        checkOutput("async_comb1", {63'd0, co1, sum1}, 65'b11);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("released_wait_q1", {63'd0, coQ1, sumQ1}, 65'd0);
        @(posedge clk);
        #1;
        checkOutput("reload_q1", {63'd0, coQ1, sumQ1}, 65'b11);

        // Eight-bit wrap-around corners.
        @(negedge clk);
        applyStimulus8(8'hFF, 8'h00, 1'b1);
        #1;
        checkOutput("wrap_ff_00_1", {56'd0, co8, sum8}, {56'd0, 1'b1, 8'h00});
        @(posedge clk);
        #1;
        checkOutput("wrap_ff_00_1_q", {56'd0, coQ8, sumQ8}, {56'd0, 1'b1, 8'h00});
        @(negedge clk);
        applyStimulus8(8'hFF, 8'hFF, 1'b1);
        #1;
        checkOutput("wrap_ff_ff_1", {56'd0, co8, sum8}, {56'd0, 1'b1, 8'hFF});
        @(negedge clk);
        applyStimulus8(8'h00, 8'h00, 1'b0);
        #1;
        checkOutput("zero_00_00_0", {56'd0, co8, sum8}, 65'd0);

        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            applyStimulus8(8'($urandom), 8'($urandom), 1'($urandom));
            #1;
            ref8 = ref_add({56'd0, a8}, {56'd0, b8}, c8, 8);
            checkOutput($sformatf("rand_comb_%0d", n), {56'd0, co8, sum8}, ref8);
            @(posedge clk);
            #1;
            checkOutput($sformatf("rand_reg_%0d", n), {56'd0, coQ8, sumQ8}, ref8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
